// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by both the target endpoint and the bus controller.
package i2c_pkg;

   localparam int ADDR_W = 7;
   localparam int BYTE_W = 8;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RACK,
      WAIT_STOP
   } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes raw SCL/SDA pads and derives single-cycle bus event pulses.
module i2c_line_sync (
   input  logic clk,
   input  logic reset,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o
);

   logic [1:0] scl_sync_q;
   logic [1:0] sda_sync_q;
   logic       scl_hist_q;
   logic       sda_hist_q;
   logic       scl_s;
   logic       sda_s;

   // Flops reset to the idle-bus level so releasing reset never fakes an edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_hist_q <= 1'b1;
         sda_hist_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[0], scl_i};
         sda_sync_q <= {sda_sync_q[0], sda_i};
         scl_hist_q <= scl_sync_q[1];
         sda_hist_q <= sda_sync_q[1];
      end
   end

   assign scl_s      = scl_sync_q[1];
   assign sda_s      = sda_sync_q[1];
   assign sda_o      = sda_s;
   assign scl_rise_o = scl_s & ~scl_hist_q;
   assign scl_fall_o = ~scl_s & scl_hist_q;
   assign start_o    = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
   assign stop_o     = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target endpoint: 7-bit address, pointer write, burst write and burst read
// into a byte-wide register file. SDA is driven open-drain; SCL is never driven.
module i2c_target_regs
   import i2c_pkg::*;
#(
   parameter logic [ADDR_W-1:0] DEV_ADDR = 7'h50
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              scl_in,
   input  logic              sda_in,
   output logic              sda_oe,
   output logic              wr_en,
   output logic [BYTE_W-1:0] wr_addr,
   output logic [BYTE_W-1:0] wr_data,
   output logic              rd_en,
   output logic [BYTE_W-1:0] rd_addr,
   input  logic [BYTE_W-1:0] rd_data,
   output logic              busy
);

   logic sda_s, scl_rise, scl_fall, start_ev, stop_ev;

   i2c_line_sync u_line_sync (
      .clk        (clk),
      .reset      (reset),
      .scl_i      (scl_in),
      .sda_i      (sda_in),
      .sda_o      (sda_s),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .start_o    (start_ev),
      .stop_o     (stop_ev)
   );

   i2c_state_e        state_q;
   logic [2:0]        bit_cnt_q;
   logic [BYTE_W-2:0] shift_q;
   logic [BYTE_W-2:0] tx_q;
   logic [BYTE_W-1:0] ptr_q;
   logic              rw_q;
   logic              rack_q;
   logic              rd_cap_q;
   logic              sda_oe_q;
   logic              busy_q;
   logic              wr_en_q;
   logic [BYTE_W-1:0] wr_addr_q;
   logic [BYTE_W-1:0] wr_data_q;
   logic              rd_en_q;
   logic [BYTE_W-1:0] rd_addr_q;
   logic [BYTE_W-1:0] rx_byte_d;

   assign rx_byte_d = {shift_q, sda_s};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         tx_q      <= '0;
         ptr_q     <= '0;
         rw_q      <= 1'b0;
         rack_q    <= 1'b0;
         rd_cap_q  <= 1'b0;
         sda_oe_q  <= 1'b0;
         busy_q    <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
      end else begin
         wr_en_q  <= 1'b0;
         rd_en_q  <= 1'b0;
         rd_cap_q <= rd_en_q;
         if (start_ev) begin
            state_q   <= ADDR;
            bit_cnt_q <= '0;
            sda_oe_q  <= 1'b0;
            rd_cap_q  <= 1'b0;
         end else if (stop_ev) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            sda_oe_q <= 1'b0;
            rd_cap_q <= 1'b0;
         end else if (rd_cap_q) begin
            // Register file answers one cycle after rd_en: load and present MSB.
            tx_q     <= rd_data[BYTE_W-2:0];
            sda_oe_q <= ~rd_data[BYTE_W-1];
            ptr_q    <= ptr_q + 8'd1;
         end else begin
            case (state_q)
               ADDR, PTR, WDATA: begin
                  if (scl_rise) begin
                     shift_q   <= rx_byte_d[BYTE_W-2:0];
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        if (state_q == ADDR) begin
                           rw_q <= rx_byte_d[0];
                           if (rx_byte_d[7:1] == DEV_ADDR && rx_byte_d[7:1] != 7'h00) begin
                              state_q <= ADDR_ACK;
                              busy_q  <= 1'b1;
                           end else begin
                              state_q <= WAIT_STOP;
                           end
                        end else if (state_q == PTR) begin
                           ptr_q   <= rx_byte_d;
                           state_q <= PTR_ACK;
                        end else begin
                           wr_en_q   <= 1'b1;
                           wr_addr_q <= ptr_q;
                           wr_data_q <= rx_byte_d;
                           ptr_q     <= ptr_q + 8'd1;
                           state_q   <= WDATA_ACK;
                        end
                     end
                  end
               end
               // First fall after bit 8 pulls SDA low; the next fall ends the ACK bit.
               ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                  if (scl_fall) begin
                     if (!sda_oe_q) begin
                        sda_oe_q <= 1'b1;
                     end else begin
                        sda_oe_q  <= 1'b0;
                        bit_cnt_q <= '0;
                        if (state_q == ADDR_ACK && rw_q) begin
                           state_q   <= RDATA;
                           rd_en_q   <= 1'b1;
                           rd_addr_q <= ptr_q;
                        end else if (state_q == ADDR_ACK) begin
                           state_q <= PTR;
                        end else begin
                           state_q <= WDATA;
                        end
                     end
                  end
               end
               RDATA: begin
                  if (scl_fall) begin
                     if (bit_cnt_q == 3'd7) begin
                        sda_oe_q  <= 1'b0;
                        rack_q    <= 1'b0;
                        bit_cnt_q <= '0;
                        state_q   <= RACK;
                     end else begin
                        sda_oe_q  <= ~tx_q[BYTE_W-2];
                        tx_q      <= {tx_q[BYTE_W-3:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                     end
                  end
               end
               RACK: begin
                  if (scl_rise) begin
                     if (sda_s == I2C_ACK) begin
                        rack_q <= 1'b1;
                     end else begin
                        state_q <= WAIT_STOP;
                     end
                  end else if (scl_fall && rack_q) begin
                     rd_en_q   <= 1'b1;
                     rd_addr_q <= ptr_q;
                     state_q   <= RDATA;
                  end
               end
               default: begin
                  sda_oe_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign sda_oe  = sda_oe_q;
   assign busy    = busy_q;
   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign rd_en   = rd_en_q;
   assign rd_addr = rd_addr_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bus-level controller model, register-file responder,
// transaction-level reference model and a negedge scoreboard monitor.
module tb_i2c_target_regs;
   import i2c_pkg::*;

   localparam int Q = 5;

   logic       clk = 1'b0;
   logic       reset;
   logic       scl_ctl;
   logic       sda_ctl;
   logic       scl_in;
   logic       sda_in;
   logic       sda_oe;
   logic       wr_en;
   logic       rd_en;
   logic       busy;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic [7:0] rd_addr;
   logic [7:0] rd_data;

   always #5 clk = ~clk;

   assign scl_in = scl_ctl;
   assign sda_in = sda_ctl & ~sda_oe;

   i2c_target_regs #(.DEV_ADDR(7'h50)) dut (
      .clk     (clk),
      .reset   (reset),
      .scl_in  (scl_in),
      .sda_in  (sda_in),
      .sda_oe  (sda_oe),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .busy    (busy)
   );

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   typedef struct {
      string       name;
      logic [31:0] act;
      logic [31:0] exp;
   } chk_t;

   wr_t        exp_wr_q[$];
   logic [7:0] exp_rd_q[$];
   chk_t       chk_q[$];
   int         n_chk = 0;
   int         n_fail = 0;
   int         oe_cnt = 0;
   int         busy_cnt = 0;
   int         strobe_cnt = 0;
   logic [7:0] mem_seed;
   logic [7:0] regfile [256];
   logic [7:0] model_mem [256];
   logic [7:0] model_ptr;

   function automatic logic [7:0] fill_val(int i);
      return 8'((i * 29 + 7) ^ int'(mem_seed));
   endfunction

   // External register file: synchronous read, data valid the cycle after rd_en
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) regfile[i] <= fill_val(i);
         rd_data <= 8'h00;
      end else begin
         if (wr_en) regfile[wr_addr] <= wr_data;
         if (rd_en) rd_data <= regfile[rd_addr];
      end
   end

   function automatic void compare(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   // Scoreboard monitor
   always @(negedge clk) begin
      chk_t c;
      wr_t  w;
      if (sda_oe) oe_cnt++;
      if (busy) busy_cnt++;
      if (wr_en || rd_en) begin
         strobe_cnt++;
         compare("strobe_overlap", 32'(wr_en & rd_en), 32'd0);
      end
      while (chk_q.size() > 0) begin
         c = chk_q.pop_front();
         compare(c.name, c.act, c.exp);
      end
      if (wr_en) begin
         if (exp_wr_q.size() == 0) compare("wr_unexpected", 32'(exp_wr_q.size()), 32'd1);
         else begin
            w = exp_wr_q.pop_front();
            compare("wr_addr", 32'(wr_addr), 32'(w.addr));
            compare("wr_data", 32'(wr_data), 32'(w.data));
         end
      end
      if (rd_en) begin
         if (exp_rd_q.size() == 0) compare("rd_unexpected", 32'(exp_rd_q.size()), 32'd1);
         else compare("rd_addr", 32'(rd_addr), 32'(exp_rd_q.pop_front()));
      end
   end

   task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
      chk_t c;
      c.name = n;
      c.act  = a;
      c.exp  = e;
      chk_q.push_back(c);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic bus_start();
      sda_ctl = 1'b1; tick(Q);
      scl_ctl = 1'b1; tick(Q);
      sda_ctl = 1'b0; tick(Q);
      scl_ctl = 1'b0; tick(Q);
   endtask

   task automatic bus_stop();
      sda_ctl = 1'b0; tick(Q);
      scl_ctl = 1'b1; tick(Q);
      sda_ctl = 1'b1; tick(Q);
   endtask

   task automatic write_bit(input logic b);
      sda_ctl = b;    tick(Q);
      scl_ctl = 1'b1; tick(2 * Q);
      scl_ctl = 1'b0; tick(Q);
   endtask

   task automatic read_bit(output logic b);
      sda_ctl = 1'b1; tick(Q);
      scl_ctl = 1'b1; tick(Q);
      b = sda_in;     tick(Q);
      scl_ctl = 1'b0; tick(Q);
   endtask

   task automatic write_byte(input logic [7:0] v, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(v[i]);
      read_bit(ack);
   endtask

   task automatic read_byte(output logic [7:0] v, input logic nack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         v[i] = b;
      end
      write_bit(nack);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 256; i++) model_mem[i] = fill_val(i);
      model_ptr = 8'h00;
   endtask

   task automatic txn_write(input logic [6:0] a7, input logic [7:0] p, input logic [7:0] data [$]);
      logic ack;
      logic hit;
      hit = (a7 == 7'h50);
      bus_start();
      write_byte({a7, 1'b0}, ack);
      check("addr_ack", 32'(ack), 32'(hit ? I2C_ACK : I2C_NACK));
      if (hit) check("busy_after_addr", 32'(busy), 32'd1);
      write_byte(p, ack);
      check("ptr_ack", 32'(ack), 32'(hit ? I2C_ACK : I2C_NACK));
      if (hit) model_ptr = p;
      foreach (data[k]) begin
         if (hit) begin
            exp_wr_q.push_back('{model_ptr, data[k]});
            model_mem[model_ptr] = data[k];
            model_ptr = model_ptr + 8'd1;
         end
         write_byte(data[k], ack);
         check("data_ack", 32'(ack), 32'(hit ? I2C_ACK : I2C_NACK));
      end
      bus_stop();
      check("busy_after_stop", 32'(busy), 32'd0);
   endtask

   task automatic read_seq(input logic set_ptr, input logic [7:0] p, input int n);
      logic       ack;
      logic [7:0] got;
      logic [7:0] exp_b [$];
      bus_start();
      if (set_ptr) begin
         write_byte(8'hA0, ack);
         check("rd_waddr_ack", 32'(ack), 32'(I2C_ACK));
         write_byte(p, ack);
         check("rd_ptr_ack", 32'(ack), 32'(I2C_ACK));
         model_ptr = p;
         bus_start();
      end
      for (int k = 0; k < n; k++) begin
         exp_rd_q.push_back(model_ptr);
         exp_b.push_back(model_mem[model_ptr]);
         model_ptr = model_ptr + 8'd1;
      end
      write_byte(8'hA1, ack);
      check("rd_addr_ack", 32'(ack), 32'(I2C_ACK));
      check("busy_in_read", 32'(busy), 32'd1);
      for (int k = 0; k < n; k++) begin
         read_byte(got, (k == n - 1) ? I2C_NACK : I2C_ACK);
         check("rd_byte", 32'(got), 32'(exp_b[k]));
      end
      bus_stop();
      check("busy_after_rd_stop", 32'(busy), 32'd0);
   endtask

   initial begin
      #900us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d [$];
      logic       ack;
      logic       found;
      int         oe0, busy0, st0;
      logic [7:0] p;

      mem_seed = 8'($urandom);
      scl_ctl  = 1'b1;
      sda_ctl  = 1'b1;
      reset    = 1'b1;
      model_reset();
      tick(5);
      reset = 1'b0;
      @(negedge clk);
      check("rst_sda_oe", 32'(sda_oe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_rd_en", 32'(rd_en), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      check("rst_rd_addr", 32'(rd_addr), 32'd0);
      tick(Q);

      // Burst write with pointer
      d = '{8'hA5, 8'h3C};
      txn_write(7'h50, 8'h10, d);

      // Pointer write, Sr, read across the 0xFF wrap, NACK on the third byte
      read_seq(1'b1, 8'hFE, 3);
      read_seq(1'b0, 8'h00, 1);

      // Foreign address: bus untouched
      oe0 = oe_cnt; busy0 = busy_cnt; st0 = strobe_cnt;
      d = '{8'h12, 8'h34};
      txn_write(7'h51, 8'h20, d);
      check("foreign_oe_cycles", 32'(oe_cnt - oe0), 32'd0);
      check("foreign_busy_cycles", 32'(busy_cnt - busy0), 32'd0);
      check("foreign_strobes", 32'(strobe_cnt - st0), 32'd0);

      // STOP after 4 bits of a data byte
      bus_start();
      write_byte(8'hA0, ack);
      check("part_addr_ack", 32'(ack), 32'(I2C_ACK));
      write_byte(8'h40, ack);
      check("part_ptr_ack", 32'(ack), 32'(I2C_ACK));
      model_ptr = 8'h40;
      st0 = strobe_cnt;
      for (int i = 0; i < 4; i++) write_bit(1'(i & 1));
      bus_stop();
      check("part_no_strobe", 32'(strobe_cnt - st0), 32'd0);
      read_seq(1'b0, 8'h00, 1);
      d = '{8'h5A};
      txn_write(7'h50, 8'h40, d);

      // General call is ignored
      oe0 = oe_cnt; st0 = strobe_cnt;
      d = '{8'h77};
      txn_write(7'h00, 8'h01, d);
      check("gcall_oe_cycles", 32'(oe_cnt - oe0), 32'd0);
      check("gcall_strobes", 32'(strobe_cnt - st0), 32'd0);

      // Reset while the target pulls SDA low for a 0 data bit
      d = '{8'h00};
      txn_write(7'h50, 8'h80, d);
      bus_start();
      write_byte(8'hA0, ack);
      write_byte(8'h80, ack);
      bus_start();
      exp_rd_q.push_back(8'h80);
      write_byte(8'hA1, ack);
      check("rst_test_addr_ack", 32'(ack), 32'(I2C_ACK));
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clk);
         if (sda_oe) found = 1'b1;
      end
      check("rdata_drives_low", 32'(found), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("rst_releases_sda", 32'(sda_oe), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      scl_ctl = 1'b1;
      sda_ctl = 1'b1;
      tick(4);
      reset = 1'b0;
      model_reset();
      tick(Q);
      read_seq(1'b0, 8'h00, 2);

      // Randomized write/read traffic
      for (int it = 0; it < 6; it++) begin
         int n;
         p = 8'($urandom);
         n = $urandom_range(1, 4);
         d.delete();
         for (int k = 0; k < n; k++) d.push_back(8'($urandom));
         txn_write(($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h50, p, d);
         read_seq(1'b1, 8'(p + 8'($urandom_range(0, 3))), $urandom_range(1, 4));
      end

      tick(4);
      check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
      check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
      tick(4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
